// File: rtl/paddle_motion_controller.sv
// Two-player paddle stepping: key-strobe stretching, press/auto-repeat FSM and
// playfield clamping for the Pong paddles.

module paddle_channel #(
  parameter int Y_W          = 3,
  parameter int Y_MAX        = 7,
  parameter int PADDLE_LEN   = 3,
  parameter int INIT_Y       = 2,
  parameter int HOLD_WIN     = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up,
  input  logic           down,
  input  logic           freeze,
  input  logic           center,
  output logic [Y_W-1:0] pos,
  output logic           moved
);
  localparam int MAX_TOP = Y_MAX - PADDLE_LEN + 1;
  localparam int HW_W    = $clog2(HOLD_WIN + 1);
  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;

  state_t          state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [HW_W-1:0] hold_cnt;
  logic            dir, act_dir, act_dir_nxt;  // 1 = down
  logic            sample, held, step;
  logic [Y_W-1:0]  pos_nxt;
  logic            moved_nxt;

  // Both keys at once cancel out and count as no sample.
  assign sample = up ^ down;
  assign held   = (hold_cnt != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
      dir      <= 1'b0;
    end else if (!freeze) begin
      if (sample) begin
        hold_cnt <= HW_W'(HOLD_WIN);
        dir      <= down;
      end else if (held) begin
        hold_cnt <= hold_cnt - HW_W'(1);
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      act_dir <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      act_dir <= act_dir_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt + CNT_W'(1);
    act_dir_nxt = act_dir;
    step        = 1'b0;
    if (center || freeze || !held) begin
      state_nxt = IDLE;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          step        = 1'b1;
          state_nxt   = DELAY;
          cnt_nxt     = '0;
          act_dir_nxt = dir;
        end
        DELAY, REPEAT: begin
          if (dir != act_dir) begin
            // reversal restarts the press cycle in the new direction
            step        = 1'b1;
            state_nxt   = DELAY;
            cnt_nxt     = '0;
            act_dir_nxt = dir;
          end else if (state == DELAY && cnt == CNT_W'(REPEAT_DELAY - 1)) begin
            step      = 1'b1;
            state_nxt = REPEAT;
            cnt_nxt   = '0;
          end else if (state == REPEAT && cnt == CNT_W'(REPEAT_RATE - 1)) begin
            step    = 1'b1;
            cnt_nxt = '0;
          end
        end
        default: begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

  // Output logic: clamped step target and change flag
  always_comb begin
    pos_nxt = pos;
    if (step) begin
      if (dir)
        pos_nxt = (pos < Y_W'(MAX_TOP)) ? pos + Y_W'(1) : pos;
      else
        pos_nxt = (pos != '0) ? pos - Y_W'(1) : pos;
    end
    moved_nxt = (pos_nxt != pos);
  end

  always_ff @(posedge clk) begin
    if (rst || center) begin
      pos   <= Y_W'(INIT_Y);
      moved <= 1'b0;
    end else begin
      pos   <= pos_nxt;
      moved <= moved_nxt;
    end
  end
endmodule

module paddle_motion_controller #(
  parameter int Y_W          = 3,
  parameter int Y_MAX        = 7,
  parameter int PADDLE_LEN   = 3,
  parameter int INIT_Y       = 2,
  parameter int HOLD_WIN     = 4,
  parameter int REPEAT_DELAY = 20,
  parameter int REPEAT_RATE  = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           up1,
  input  logic           down1,
  input  logic           up2,
  input  logic           down2,
  input  logic           freeze,
  input  logic           center,
  output logic [Y_W-1:0] pad1_y,
  output logic [Y_W-1:0] pad2_y,
  output logic           moved1,
  output logic           moved2
);
  localparam int NUM_CH = 2;

  logic [NUM_CH-1:0]          up_v, down_v, moved_v;
  logic [NUM_CH-1:0][Y_W-1:0] pos_v;

  assign up_v   = {up2, up1};
  assign down_v = {down2, down1};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    paddle_channel #(
      .Y_W(Y_W), .Y_MAX(Y_MAX), .PADDLE_LEN(PADDLE_LEN), .INIT_Y(INIT_Y),
      .HOLD_WIN(HOLD_WIN), .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)
    ) u_ch (
      .clk(clk), .rst(rst), .up(up_v[g]), .down(down_v[g]),
      .freeze(freeze), .center(center), .pos(pos_v[g]), .moved(moved_v[g])
    );
  end

  assign pad1_y = pos_v[0];
  assign pad2_y = pos_v[1];
  assign moved1 = moved_v[0];
  assign moved2 = moved_v[1];
endmodule

// File: tb/tb_paddle_motion_controller.sv
// Directed bench for paddle_motion_controller: hand-computed positions per cycle.

module tb_paddle_motion_controller;
  logic       clk = 0, rst = 1;
  logic       up1 = 0, down1 = 0, up2 = 0, down2 = 0, freeze = 0, center = 0;
  logic [2:0] pad1_y, pad2_y;
  logic       moved1, moved2;

  int nvec = 0, nerr = 0;
  int h1 [0:99];
  int h2 [0:99];
  int mv1c, mv2c;

  localparam logic [3:0] K_U1 = 4'b0001, K_D1 = 4'b0010, K_U2 = 4'b0100, K_D2 = 4'b1000;

  paddle_motion_controller dut (
    .clk(clk), .rst(rst), .up1(up1), .down1(down1), .up2(up2), .down2(down2),
    .freeze(freeze), .center(center), .pad1_y(pad1_y), .pad2_y(pad2_y),
    .moved1(moved1), .moved2(moved2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    nvec++;
    if (obs != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // n cycles; keys strobed on cycle 0,4,8,... (scanner row phase).
  // h*[i] holds the pad position seen just after edge i of this run.
  task automatic run(input int n, input logic [3:0] keys);
    mv1c = 0; mv2c = 0;
    for (int i = 0; i < n; i++) begin
      logic [3:0] k;
      k = (i % 4 == 0) ? keys : 4'b0000;
      {down2, up2, down1, up1} = k;
      @(posedge clk); #1;
      h1[i] = pad1_y; h2[i] = pad2_y;
      mv1c += moved1; mv2c += moved2;
    end
    {down2, up2, down1, up1} = 4'b0000;
  endtask

  task automatic do_reset();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pad1", pad1_y, 2);
    chk("rst_pad2", pad2_y, 2);
    chk("rst_mv1", moved1, 0);
    chk("rst_mv2", moved2, 0);
    rst = 0;
  endtask

  initial begin
    do_reset();

    // single tap
    run(12, K_U1);
    chk("tap_k", h1[0], 2);
    chk("tap_k1", h1[1], 1);
    chk("tap_mvcnt", mv1c, 1);
    run(30, 4'b0000);
    chk("tap_norep_mv", mv1c, 0);
    chk("tap_hold", pad1_y, 1);
    chk("tap_p2", pad2_y, 2);

    // auto-repeat with clamp at bottom (max top = 5)
    run(60, K_D2);
    chk("rep_k", h2[0], 2);
    chk("rep_k1", h2[1], 3);
    chk("rep_k20", h2[20], 3);
    chk("rep_k21", h2[21], 4);
    chk("rep_k28", h2[28], 4);
    chk("rep_k29", h2[29], 5);
    chk("rep_k59", h2[59], 5);
    chk("rep_mvcnt", mv2c, 3);
    run(20, 4'b0000);
    chk("rep_after_mv", mv2c, 0);
    chk("rep_after_pos", pad2_y, 5);

    // direction reversal: p1 from 1 down into REPEAT at 4
    run(30, K_D1);
    chk("rev_d1", h1[1], 2);
    chk("rev_d21", h1[21], 3);
    chk("rev_d29", h1[29], 4);
    run(24, K_U1);
    chk("rev_u0", h1[0], 4);
    chk("rev_u1", h1[1], 3);
    chk("rev_u20", h1[20], 3);
    chk("rev_u21", h1[21], 2);
    run(20, 4'b0000);
    chk("rev_rel_mv", mv1c, 0);
    chk("rev_rel_pos", pad1_y, 2);

    // freeze then release while pressing
    freeze = 1;
    run(30, K_U1);
    chk("frz_pos", pad1_y, 2);
    chk("frz_mv", mv1c, 0);
    freeze = 0;
    run(8, K_U1);
    chk("unfrz_k", h1[0], 2);
    chk("unfrz_k1", h1[1], 1);

    // center with keys active
    center = 1;
    run(4, K_U1 | K_D2);
    chk("ctr_p1", h1[0], 2);
    chk("ctr_p2", h2[0], 2);
    chk("ctr_p1_3", h1[3], 2);
    chk("ctr_mv1", mv1c, 0);
    chk("ctr_mv2", mv2c, 0);
    run(4, 4'b0000);
    center = 0;
    run(10, 4'b0000);
    chk("ctr_rel_p1", pad1_y, 2);
    chk("ctr_rel_mv", mv1c + mv2c, 0);

    // simultaneous up/down cancel
    run(20, K_U1 | K_D1);
    chk("both_pos", pad1_y, 2);
    chk("both_mv", mv1c, 0);

    // both players into REPEAT, then reset mid-operation
    run(32, K_U1 | K_D2);
    chk("pre_p1_1", h1[1], 1);
    chk("pre_p1_21", h1[21], 0);
    chk("pre_p1_31", h1[31], 0);
    chk("pre_p2_31", h2[31], 5);
    chk("pre_mv1_clamp", mv1c, 2);
    chk("pre_mv2", mv2c, 3);
    do_reset();
    run(10, 4'b0000);
    chk("post_rst_p1", pad1_y, 2);
    chk("post_rst_p2", pad2_y, 2);
    chk("post_rst_mv", mv1c + mv2c, 0);
    run(4, K_D1);
    chk("fresh_k", h1[0], 2);
    chk("fresh_k1", h1[1], 3);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
